// File: rtl/display_scan_ctrl_if.sv
// Scan controller bus: the enable/readback bus to the digit registers plus
// the display drive outputs. The master side (driver/bench) owns scan_en and
// bus_in; the slave side (the controller) owns everything else.
interface display_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic              scan_en;
   logic [4:0]        bus_in;
   logic [DIGITS-1:0] oe_out;
   logic [DIGITS-1:0] anode_n;
   logic [6:0]        seg_n;
   logic [IDX_W-1:0]  digit_idx;
   logic              frame_tick;

   modport master (
      output scan_en, bus_in,
      input  oe_out, anode_n, seg_n, digit_idx, frame_tick
   );

   modport slave (
      input  scan_en, bus_in,
      output oe_out, anode_n, seg_n, digit_idx, frame_tick
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller. Each digit slot starts with a blank
// interval (register output-enabled, anodes off) during which the register
// code is read from the wired-OR bus, then the digit is shown from the
// captured code for the rest of the slot. All drive outputs are registered.
module display_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input logic               clock,
   input logic               reset,
   display_scan_ctrl_if.slave bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [4:0]        code;
   logic [DIGITS-1:0] oe_reg;
   logic [DIGITS-1:0] anode_reg;
   logic [6:0]        seg_reg;
   logic              tick_reg;
   logic [IDX_W-1:0]  idx_next;

   // Glyph decode: hex 0-F, 0x10 minus sign, everything else blank.
   function automatic logic [6:0] decode(input logic [4:0] c);
      logic [6:0] s;
      case (c)
         5'h00: s = 7'h40;
         5'h01: s = 7'h79;
         5'h02: s = 7'h24;
         5'h03: s = 7'h30;
         5'h04: s = 7'h19;
         5'h05: s = 7'h12;
         5'h06: s = 7'h02;
         5'h07: s = 7'h78;
         5'h08: s = 7'h00;
         5'h09: s = 7'h10;
         5'h0A: s = 7'h08;
         5'h0B: s = 7'h03;
         5'h0C: s = 7'h46;
         5'h0D: s = 7'h21;
         5'h0E: s = 7'h06;
         5'h0F: s = 7'h0E;
         5'h10: s = 7'h3F;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [DIGITS-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Digit index after the current slot, wrapping at the last digit.
   always_comb begin
      idx_next = idx + 1'b1;
      if (idx == IDX_W'(DIGITS - 1)) idx_next = '0;
   end

   // Scan FSM with registered drive outputs; reset and scan_en low both force IDLE.
   always_ff @(posedge clock) begin
      if (reset || !bus.scan_en) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         tick_reg  <= 1'b0;
         oe_reg    <= '0;
         anode_reg <= '1;
         seg_reg   <= 7'h7F;
         if (reset) code <= 5'h11;
      end else begin
         case (state)
            IDLE: begin
               state     <= BLANK;
               cnt       <= '0;
               idx       <= '0;
               tick_reg  <= 1'b0;
               oe_reg    <= onehot('0);
               anode_reg <= '1;
               seg_reg   <= 7'h7F;
            end
            BLANK: begin
               tick_reg <= 1'b0;
               cnt      <= cnt + 1'b1;
               if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                  // The register has had the whole blank interval to settle the bus.
                  code      <= ~bus.bus_in;
                  state     <= SHOW;
                  anode_reg <= ~onehot(idx);
                  seg_reg   <= decode(~bus.bus_in);
               end
            end
            SHOW: begin
               if (cnt == CNT_W'(SLOT_CYCLES - 1)) begin
                  cnt       <= '0;
                  idx       <= idx_next;
                  state     <= BLANK;
                  oe_reg    <= onehot(idx_next);
                  anode_reg <= '1;
                  seg_reg   <= 7'h7F;
                  tick_reg  <= (idx == IDX_W'(DIGITS - 1));
               end else begin
                  cnt      <= cnt + 1'b1;
                  tick_reg <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               idx       <= '0;
               tick_reg  <= 1'b0;
               oe_reg    <= '0;
               anode_reg <= '1;
               seg_reg   <= 7'h7F;
            end
         endcase
      end
   end

   assign bus.oe_out     = oe_reg;
   assign bus.anode_n    = anode_reg;
   assign bus.seg_n      = seg_reg;
   assign bus.digit_idx  = idx;
   assign bus.frame_tick = tick_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
// A timeline model predicts every cycle's outputs into a scoreboard queue;
// a glyph table and directed sequences cover decode and control corners.
module tb_display_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int SLOT   = 8;
   localparam int BLANK  = 2;
   localparam int FRAME  = SLOT * DIGITS;

   logic clock = 1'b0;
   logic reset = 1'b1;

   display_scan_ctrl_if #(.DIGITS(DIGITS)) dif ();

   display_scan_ctrl #(
      .DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
   ) dut (
      .clock(clock), .reset(reset), .bus(dif)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [4:0] codes [DIGITS];

   // Digit registers on a wired-OR bus: the enabled one drives its inverted code.
   always_comb begin
      dif.bus_in = 5'h00;
      for (int k = 0; k < DIGITS; k++)
         if (dif.oe_out[k]) dif.bus_in = dif.bus_in | ~codes[k];
   end

   function automatic logic [6:0] glyph(input logic [4:0] c);
      logic [6:0] t [17];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F};
      if (c <= 5'h10) return t[c];
      return 7'h7F;
   endfunction

   typedef struct packed {
      logic [3:0] oe;
      logic [3:0] an;
      logic [6:0] seg;
      logic [1:0] idx;
      logic       ft;
   } exp_t;

   exp_t sb[$];

   // Timeline model: t counts cycles since the scan started.
   bit         active = 0;
   int         t = 0;
   logic [4:0] mcode = 5'h11;

   always @(posedge clock) begin
      exp_t e;
      int   d, c;
      if (reset || !dif.scan_en) begin
         active = 0;
         t      = 0;
      end else if (!active) begin
         active = 1;
         t      = 0;
      end else begin
         t = t + 1;
      end
      d = (t / SLOT) % DIGITS;
      c = t % SLOT;
      if (active && c == BLANK) mcode = codes[d];
      if (!active) begin
         e = '{oe: 4'h0, an: 4'hF, seg: 7'h7F, idx: 2'd0, ft: 1'b0};
      end else begin
         e.oe  = 4'(1 << d);
         e.an  = (c >= BLANK) ? ~4'(1 << d) : 4'hF;
         e.seg = (c >= BLANK) ? glyph(mcode) : 7'h7F;
         e.idx = 2'(d);
         e.ft  = (t > 0) && (t % FRAME == 0);
      end
      sb.push_back(e);
   end

   // Scoreboard compare plus per-cycle one-hot / blank-interval invariants.
   always @(negedge clock) begin
      exp_t e, a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = '{oe: dif.oe_out, an: dif.anode_n, seg: dif.seg_n,
               idx: dif.digit_idx, ft: dif.frame_tick};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL sb t=%0d: got oe=%b an=%b seg=%h idx=%0d ft=%b, want oe=%b an=%b seg=%h idx=%0d ft=%b",
                     t, a.oe, a.an, a.seg, a.idx, a.ft, e.oe, e.an, e.seg, e.idx, e.ft);
         end
      end
      checks++;
      if ($countones(dif.oe_out) > 1 || $countones(~dif.anode_n) > 1) begin
         errors++;
         $display("FAIL onehot: got oe=%b an=%b, want at most one active each", dif.oe_out, dif.anode_n);
      end
      checks++;
      if (dif.anode_n != 4'hF && active && (t % SLOT) < BLANK) begin
         errors++;
         $display("FAIL blank_anode: got an=%b in blank interval, want 1111", dif.anode_n);
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      dif.scan_en = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic set_codes(input logic [4:0] c0, input logic [4:0] c1,
                            input logic [4:0] c2, input logic [4:0] c3);
      codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
   endtask

   // Advance until the model position reaches target, bounded.
   task automatic wait_t(input int target);
      int n = 0;
      while (!(active && t == target) && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (!(active && t == target)) begin
         errors++;
         $display("FAIL wait_t: got t=%0d, want %0d", t, target);
      end
   endtask

   typedef struct {
      logic [4:0] code;
      logic [6:0] seg;
   } vec_t;

   initial begin
      vec_t vecs [20];
      int   ticks;
      vecs = '{'{5'h00, 7'h40}, '{5'h01, 7'h79}, '{5'h02, 7'h24}, '{5'h03, 7'h30},
               '{5'h04, 7'h19}, '{5'h05, 7'h12}, '{5'h06, 7'h02}, '{5'h07, 7'h78},
               '{5'h08, 7'h00}, '{5'h09, 7'h10}, '{5'h0A, 7'h08}, '{5'h0B, 7'h03},
               '{5'h0C, 7'h46}, '{5'h0D, 7'h21}, '{5'h0E, 7'h06}, '{5'h0F, 7'h0E},
               '{5'h10, 7'h3F}, '{5'h11, 7'h7F}, '{5'h15, 7'h7F}, '{5'h1F, 7'h7F}};
      set_codes(5'h01, 5'h02, 5'h03, 5'h04);
      dif.scan_en = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_oe", dif.oe_out, 4'h0);
      check("reset_an", dif.anode_n, 4'hF);
      check("reset_seg", dif.seg_n, 7'h7F);
      check("reset_ft", dif.frame_tick, 0);

      // Glyph table: every digit holds the vector code, check digit 0 in SHOW.
      for (int i = 0; i < 20; i++) begin
         set_codes(vecs[i].code, vecs[i].code, vecs[i].code, vecs[i].code);
         do_reset();
         dif.scan_en = 1'b1;
         repeat (BLANK + 1) @(posedge clock);
         @(negedge clock);
         check($sformatf("glyph_%0h", vecs[i].code), dif.seg_n, vecs[i].seg);
         check("glyph_an", dif.anode_n, 4'hE);
      end

      // Normal scan: two frame ticks within 70 cycles of enabling.
      set_codes(5'h01, 5'h02, 5'h03, 5'h04);
      do_reset();
      dif.scan_en = 1'b1;
      ticks = 0;
      repeat (70) begin
         @(negedge clock);
         if (dif.frame_tick) ticks++;
      end
      check("frame_ticks", ticks, 2);

      // Minus sign on digit 2, blank code on digit 3.
      set_codes(5'h01, 5'h02, 5'h10, 5'h1F);
      do_reset();
      dif.scan_en = 1'b1;
      wait_t(2 * SLOT + BLANK);
      @(negedge clock);
      check("minus_seg", dif.seg_n, 7'h3F);
      check("minus_an", dif.anode_n, 4'hB);
      wait_t(3 * SLOT + BLANK);
      @(negedge clock);
      check("blank_seg", dif.seg_n, 7'h7F);
      check("blank_an", dif.anode_n, 4'h7);

      // Bus change mid-SHOW of digit 0 only shows up in its next slot.
      set_codes(5'h01, 5'h02, 5'h03, 5'h04);
      do_reset();
      dif.scan_en = 1'b1;
      wait_t(4);
      codes[0] = 5'h08;
      @(negedge clock);
      check("hold_seg_a", dif.seg_n, 7'h79);
      wait_t(7);
      @(negedge clock);
      check("hold_seg_b", dif.seg_n, 7'h79);
      wait_t(FRAME + BLANK);
      @(negedge clock);
      check("next_slot_seg", dif.seg_n, 7'h00);

      // scan_en dropped at cnt=5 of digit 2, then reasserted.
      set_codes(5'h01, 5'h02, 5'h03, 5'h04);
      do_reset();
      dif.scan_en = 1'b1;
      wait_t(2 * SLOT + 5);
      dif.scan_en = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("drop_oe", dif.oe_out, 4'h0);
      check("drop_an", dif.anode_n, 4'hF);
      check("drop_seg", dif.seg_n, 7'h7F);
      check("drop_idx", dif.digit_idx, 0);
      #1 dif.scan_en = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("restart_oe", dif.oe_out, 4'h1);
      check("restart_an", dif.anode_n, 4'hF);
      check("restart_idx", dif.digit_idx, 0);

      // One-cycle reset at cnt=3 of digit 1.
      wait_t(SLOT + 3);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_mid_oe", dif.oe_out, 4'h0);
      check("rst_mid_an", dif.anode_n, 4'hF);
      check("rst_mid_ft", dif.frame_tick, 0);
      check("rst_mid_idx", dif.digit_idx, 0);
      repeat (40) @(posedge clock);
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
